// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier, WIDTH-bit operands, 2*WIDTH-bit product.
// One Booth step per clock; run-time signed/unsigned selection via operand extension.
module booth_multiplier_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 sys_clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplier_in,
  input  logic [WIDTH-1:0]     multiplicand_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned AW = W1 + 1;
  localparam int unsigned CW = $clog2(W1 + 1);
  localparam int unsigned RW = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_a, w_a_nxt;
  logic [W1-1:0]   r_q, w_q_nxt;
  logic [W1-1:0]   r_m, w_m_nxt;
  logic            r_qm1, w_qm1_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic [RW-1:0]   r_result, w_result_nxt;

  logic [AW-1:0]   w_addend;
  logic [AW-1:0]   w_sum;
  logic [AW-1:0]   w_a_sh;
  logic [W1-1:0]   w_q_sh;

  // Booth add/subtract followed by arithmetic right shift of {A,Q,q_m1}
  always_comb begin
    w_addend = {r_m[W1-1], r_m};
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_a + w_addend;
      2'b10:   w_sum = r_a - w_addend;
      default: w_sum = r_a;
    endcase
    w_a_sh = {w_sum[AW-1], w_sum[AW-1:1]};
    w_q_sh = {w_sum[0], r_q[W1-1:1]};
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_q_nxt      = r_q;
    w_m_nxt      = r_m;
    w_qm1_nxt    = r_qm1;
    w_cnt_nxt    = r_cnt;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_m_nxt     = signed_mode ? {multiplicand_in[WIDTH-1], multiplicand_in}
                                    : {1'b0, multiplicand_in};
          w_q_nxt     = signed_mode ? {multiplier_in[WIDTH-1], multiplier_in}
                                    : {1'b0, multiplier_in};
          w_a_nxt     = '0;
          w_qm1_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_a_nxt   = w_a_sh;
        w_q_nxt   = w_q_sh;
        w_qm1_nxt = r_q[0];
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(W1 - 1)) begin
          // Low 2*WIDTH bits of {A,Q}: all of Q plus the low WIDTH-1 bits of A
          w_result_nxt = {w_a_sh[WIDTH-2:0], w_q_sh};
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_DONE;
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_qm1    <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_q      <= w_q_nxt;
      r_m      <= w_m_nxt;
      r_qm1    <= w_qm1_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: doc/booth_multiplier_seq.md
Name: booth_multiplier_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier. It succeeds the fixed 8-bit Booth multiplier block.
- Adds:
  - generic operand width
  - run-time signed/unsigned mode
  - an explicit busy/done handshake, replacing the internal equality flag.
- Sits between switch/register operand sources and the LED/display result path; reusable as a datapath core.

Parameters:
- WIDTH, 8, operand width in bits (>=2); result is 2*WIDTH bits.

Ports:
- sys_clock  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; level-sampled only in IDLE
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with operands
- multiplier_in  input  WIDTH  multiplier operand
- multiplicand_in  input  WIDTH  multiplicand operand
- busy  output  1  high from accept edge until the edge the result is written
- done  output  1  one-cycle pulse; result valid and updated
- result  output  2*WIDTH  product; held until next completion

Behaviour:
- Reset (sync, active-high, priority over everything):
  - state=IDLE
  - busy=0, done=0, result=0
  - internal A/Q/M/q_m1/count cleared.
  - Applies mid-operation: the computation is abandoned and result is forced to 0.
- Internal width W1=WIDTH+1.
  - Operands are extended to W1 bits at accept: sign-extended if signed_mode=1, zero-extended if 0.
  - This makes a single Booth datapath serve both modes.
- Registers:
  - M (W1, multiplicand)
  - Q (W1, multiplier)
  - q_m1 (1)
  - A (W1+1, accumulator; extra bit absorbs overflow when subtracting the most negative M)
  - count (clog2(W1+1) bits).
- FSM states IDLE, RUN, DONE:
  - IDLE:
    - busy=0.
    - If start=1 at an edge:
      - latch extended operands into M/Q
      - set A=0, q_m1=0, count=0
      - go to RUN, busy=1.
  - RUN, one Booth step per edge:
    - {Q0,q_m1}=01 → A=A+M; =10 → A=A−M (M sign-extended to W1+1); 00/11 → no add.
    - Then arithmetic right shift of {A,Q,q_m1} by 1 (A MSB replicated).
    - count++.
    - The edge performing step W1 (count==W1−1) writes result = low 2*WIDTH bits of the shifted {A,Q}, sets state=DONE and busy=0.
  - DONE:
    - done=1 for exactly this cycle.
    - Next edge → IDLE unconditionally.
    - start in DONE is ignored.
- Latency: done is high in the cycle beginning W1 edges after the accept edge (9 cycles for WIDTH=8). Minimum accept-to-accept period is W1+2 cycles.
- start while busy or in DONE: ignored. Operand and mode inputs may change freely after the accept edge with no effect.
- start held continuously high: re-accepted on the first IDLE edge after DONE (back-to-back operations, period W1+2).
- Truncating to 2*WIDTH bits is exact in both modes: signed range ±2^(2*WIDTH−2), unsigned max (2^WIDTH−1)^2.
- result changes only on the completion edge or reset. done and busy are never high together.

Test Plan:
- WIDTH=8, signed_mode=1, 7×7 → done after 9 cycles, result=0x0031; busy high exactly 9 cycles.
- WIDTH=8, signed_mode=1:
  - −4×−4 (0xFC,0xFC) → 0x0010
  - 7×−4 → 0xFFE4
  - −4×7 → 0xFFE4
  - −128×−128 (0x80,0x80) → 0x4000
- WIDTH=8, signed_mode=0:
  - 0xFF×0xFF → 0xFE01
  - 0xFC×0x07 → 0x06E4
  - same 0xFF×0xFF with signed_mode=1 → 0x0001
- start pulsed again 3 cycles after accept, with new operands 2×3 → ignored; result is that of the first operation; no extra done pulse.
- reset asserted for 1 cycle at RUN cycle 4 → next cycle busy=0, done=0, result=0x0000; a fresh 7×7 then completes normally with 0x0031.
- WIDTH=16 instance, signed: 0x8000×0x8000 → 0x40000000; unsigned 0xFFFF×0xFFFF → 0xFFFE0001. Latency 17 cycles; start held high gives done pulses every 19 cycles.
